// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states,
// ALU control codes, condition codes, instruction classes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } statetype_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_RD1      = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

endpackage

// File: rtl/mc_control_unit_cond.sv
// Condition unit: stored NZCV flags, latched condition result for the current
// instruction, and the condition-code evaluation against the stored flags.
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       decode_en,
    output logic       cond_ex_q
);

    logic [3:0] flags_r;
    logic       cond_ex_r;
    logic       cond_ex_s;
    logic       n_s, z_s, c_s, v_s;

    assign {n_s, z_s, c_s, v_s} = flags_r;
    assign cond_ex_q = cond_ex_r;

    // Evaluate the condition field against the flags committed so far
    always_comb begin
        cond_ex_s = 1'b0;
        case (cond)
            COND_EQ: cond_ex_s = z_s;
            COND_NE: cond_ex_s = ~z_s;
            COND_CS: cond_ex_s = c_s;
            COND_CC: cond_ex_s = ~c_s;
            COND_MI: cond_ex_s = n_s;
            COND_PL: cond_ex_s = ~n_s;
            COND_VS: cond_ex_s = v_s;
            COND_VC: cond_ex_s = ~v_s;
            COND_HI: cond_ex_s = c_s & ~z_s;
            COND_LS: cond_ex_s = ~c_s | z_s;
            COND_GE: cond_ex_s = (n_s == v_s);
            COND_LT: cond_ex_s = (n_s != v_s);
            COND_GT: cond_ex_s = ~z_s & (n_s == v_s);
            COND_LE: cond_ex_s = z_s | (n_s != v_s);
            COND_AL: cond_ex_s = 1'b1;
            default: cond_ex_s = 1'b0;
        endcase
    end

    // Latch the condition in DECODE; a failed condition also blocks the flag write
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r   <= 4'b0000;
            cond_ex_r <= 1'b0;
        end else begin
            if (decode_en) begin
                cond_ex_r <= cond_ex_s;
            end
            if (flag_w[1] & cond_ex_r) begin
                flags_r[3:2] <= alu_flags[3:2];
            end
            if (flag_w[0] & cond_ex_r) begin
                flags_r[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control unit: main FSM, ALU decoder and write gating for the
// ARM-subset datapath. Outputs are combinational from state and instruction fields.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] PC_REG = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    statetype_t state_r;
    logic       next_pc_s, ir_write_s, reg_w_s, mem_w_s, branch_s, alu_op_s;
    logic       pcs_s, cond_ex_q_s;
    logic [1:0] flag_w_s;
    logic [3:0] cmd_s;

    assign cmd_s = Funct[4:1];

    // Main FSM state register and transitions
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            case (state_r)
                FETCH:  state_r <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_MEM:  state_r <= MEMADR;
                        OP_DP:   state_r <= Funct[5] ? EXECI : EXECR;
                        OP_BR:   state_r <= BRANCH;
                        default: state_r <= FETCH;
                    endcase
                end
                MEMADR: state_r <= Funct[0] ? MEMRD : MEMWR;
                MEMRD:  state_r <= MEMWB;
                EXECR:  state_r <= ALUWB;
                EXECI:  state_r <= ALUWB;
                default: state_r <= FETCH;
            endcase
        end
    end

    // Per-state control decode; anything not driven stays at its zero select
    always_comb begin
        next_pc_s  = 1'b0;
        ir_write_s = 1'b0;
        reg_w_s    = 1'b0;
        mem_w_s    = 1'b0;
        branch_s   = 1'b0;
        alu_op_s   = 1'b0;
        AdrSrc     = ADR_PC;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        case (state_r)
            FETCH: begin
                ir_write_s = 1'b1;
                next_pc_s  = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR: ALUSrcB = SRCB_IMM;
            MEMRD:  AdrSrc  = ADR_ALUOUT;
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w_s   = 1'b1;
            end
            MEMWR: begin
                AdrSrc  = ADR_ALUOUT;
                mem_w_s = 1'b1;
            end
            EXECR:  alu_op_s = 1'b1;
            EXECI: begin
                ALUSrcB  = SRCB_IMM;
                alu_op_s = 1'b1;
            end
            ALUWB:  reg_w_s = 1'b1;
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch_s  = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder; only ADD/SUB are allowed to update C and V
    always_comb begin
        ALUControl = ALU_ADD;
        flag_w_s   = 2'b00;
        if (alu_op_s) begin
            case (cmd_s)
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                default: ALUControl = ALU_ADD;
            endcase
            flag_w_s[1] = Funct[0];
            flag_w_s[0] = Funct[0] & ((cmd_s == CMD_ADD) | (cmd_s == CMD_SUB));
        end else begin
            ALUControl = ALU_ADD;
            flag_w_s   = 2'b00;
        end
    end

    cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w_s),
        .decode_en (state_r == DECODE),
        .cond_ex_q (cond_ex_q_s)
    );

    assign pcs_s    = ((Rd == PC_REG) & reg_w_s) | branch_s;
    assign PCWrite  = ~reset & (next_pc_s | (pcs_s & cond_ex_q_s));
    assign RegWrite = ~reset & reg_w_s & cond_ex_q_s;
    assign MemWrite = ~reset & mem_w_s & cond_ex_q_s;
    assign IRWrite  = ~reset & ir_write_s;
    assign ImmSrc   = Op;
    assign RegSrc   = {(Op == OP_MEM), (Op == OP_BR)};

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: instruction-level reference model
// producing the expected per-cycle control vector, directed and random instructions.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl;

    int asserts = 0;
    int fails   = 0;
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    logic [3:0]  m_flags;

    mc_control_unit dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    // Vector layout: [16]PCW [15]Adr [14]MemW [13]IRW [12]RegW [11:10]Res [9:8]A [7:6]B [5:4]ALUC [3:2]Imm [1:0]RegSrc
    function automatic logic [16:0] pk(input logic pcw, adr, memw, irw, regw,
                                       input logic [1:0] res, sa, sb, ac, imm, rs);
        return {pcw, adr, memw, irw, regw, res, sa, sb, ac, imm, rs};
    endfunction

    // Conditions come in complementary pairs; 111x is always / never
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (cond[3:1] == 3'b111) ? ~cond[0] : (base ^ cond[0]);
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Reference model: append the instruction's expected cycles, then commit flags
    task automatic model_instr(input logic [3:0] cond, input logic [1:0] op,
                               input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] aluf);
        logic pass, pc15;
        logic [1:0] rs;
        pass = cond_holds(cond, m_flags);
        pc15 = pass && (rd == 4'd15);
        rs = {op == 2'b01, op == 2'b10};
        exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, op, rs));
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, op, rs));
        case (op)
            2'b01: begin
                exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, op, rs));
                if (funct[0]) begin
                    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, op, rs));
                    exp_q.push_back(pk(pc15, 1'b0, 1'b0, 1'b0, pass, 2'b01, 2'b00, 2'b00, 2'b00, op, rs));
                end else begin
                    exp_q.push_back(pk(1'b0, 1'b1, pass, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, op, rs));
                end
            end
            2'b00: begin
                exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                                   funct[5] ? 2'b01 : 2'b00, alu_of(funct[4:1]), op, rs));
                exp_q.push_back(pk(pc15, 1'b0, 1'b0, 1'b0, pass, 2'b00, 2'b00, 2'b00, 2'b00, op, rs));
                if (pass && funct[0]) begin
                    m_flags[3:2] = aluf[3:2];
                    if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010) m_flags[1:0] = aluf[1:0];
                end
            end
            2'b10: exp_q.push_back(pk(pass, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, op, rs));
            default: ;
        endcase
    endtask

    // Model one instruction, drive it from FETCH and record the DUT's vector each cycle
    task automatic do_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                            input logic [3:0] rd, input logic [3:0] aluf, output int base);
        base = exp_q.size();
        model_instr(cond, op, funct, rd, aluf);
        Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = aluf;
        for (int i = base; i < exp_q.size(); i++) begin
            @(negedge clk);
            obs_q.push_back(pk(PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc));
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int b;
        exp_q.delete(); obs_q.delete();
        reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            asserts++;
            if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
                fails++; $display("FAIL reset_we got %b exp 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_flags = 4'b0000;
        do_instr(4'hE, 2'b00, 6'b001000, 4'd2, 4'd0, b);
        asserts++;
        if ({obs_q[b][13], obs_q[b][16], obs_q[b][15], obs_q[b][7:6]} !== 5'b11010) begin
            fails++; $display("FAIL first_fetch got %h exp IRW=1 PCW=1 Adr=0 B=10", obs_q[b]);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL reset_seq cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_subs_beq();
        int b0, b1;
        exp_q.delete(); obs_q.delete();
        do_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0110, b0);
        do_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, b1);
        asserts++;
        if (obs_q[b0+2][5:4] !== 2'b01) begin fails++; $display("FAIL subs_aluc got %b exp 01", obs_q[b0+2][5:4]); end
        asserts++;
        if (obs_q[b1+2][16] !== 1'b1) begin fails++; $display("FAIL beq_taken got %b exp 1", obs_q[b1+2][16]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL subs_beq cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_cond_fail();
        int b0, b1, b2;
        exp_q.delete(); obs_q.delete();
        do_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0000, b0);
        do_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b1111, b1);
        do_instr(4'h1, 2'b00, 6'b001000, 4'd3, 4'b1111, b2);
        asserts++;
        if (obs_q[b1+2][16] !== 1'b0) begin fails++; $display("FAIL beq_not_taken got %b exp 0", obs_q[b1+2][16]); end
        asserts++;
        if (obs_q[b2+3][12] !== 1'b1) begin fails++; $display("FAIL addne_regw got %b exp 1", obs_q[b2+3][12]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL cond_fail cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mem();
        int b0, b1, b2;
        exp_q.delete(); obs_q.delete();
        do_instr(4'hE, 2'b01, 6'b011001, 4'd4, 4'd0, b0);
        do_instr(4'hE, 2'b01, 6'b011000, 4'd5, 4'd0, b1);
        do_instr(4'hF, 2'b01, 6'b011000, 4'd5, 4'd0, b2);
        asserts++;
        if (b1 - b0 != 5 || obs_q[b0+4][12] !== 1'b1) begin fails++; $display("FAIL ldr_wb len %0d regw %b exp 5 1", b1 - b0, obs_q[b0+4][12]); end
        asserts++;
        if (obs_q[b1+3][14] !== 1'b1) begin fails++; $display("FAIL str_memw got %b exp 1", obs_q[b1+3][14]); end
        asserts++;
        if (obs_q[b2+3][14] !== 1'b0) begin fails++; $display("FAIL str_nv_memw got %b exp 0", obs_q[b2+3][14]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL mem cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_orr_ands();
        int b0, b1, b2, b3, b4;
        exp_q.delete(); obs_q.delete();
        do_instr(4'hE, 2'b00, 6'b111000, 4'd6, 4'b1111, b0);
        do_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, b1);
        do_instr(4'hE, 2'b00, 6'b000001, 4'd6, 4'b0110, b2);
        do_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, b3);
        do_instr(4'h2, 2'b10, 6'b000000, 4'd0, 4'b0000, b4);
        asserts++;
        if (obs_q[b0+2][5:4] !== 2'b11) begin fails++; $display("FAIL orr_aluc got %b exp 11", obs_q[b0+2][5:4]); end
        asserts++;
        if (obs_q[b1+2][16] !== 1'b0) begin fails++; $display("FAIL orr_no_flags got %b exp 0", obs_q[b1+2][16]); end
        asserts++;
        if (obs_q[b3+2][16] !== 1'b1) begin fails++; $display("FAIL ands_z_set got %b exp 1", obs_q[b3+2][16]); end
        asserts++;
        if (obs_q[b4+2][16] !== 1'b0) begin fails++; $display("FAIL ands_c_held got %b exp 0", obs_q[b4+2][16]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL orr_ands cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_pc_write();
        int b0;
        exp_q.delete(); obs_q.delete();
        do_instr(4'hE, 2'b00, 6'b001000, 4'd15, 4'd0, b0);
        asserts++;
        if ({obs_q[b0+3][12], obs_q[b0+3][16]} !== 2'b11) begin
            fails++; $display("FAIL add_pc got regw,pcw=%b exp 11", {obs_q[b0+3][12], obs_q[b0+3][16]});
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL pc_write cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd1; ALUFlags = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            asserts++;
            if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
                fails++; $display("FAIL mid_reset_we got %b exp 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        m_flags = 4'b0000;
        @(negedge clk);
        asserts++;
        if ({IRWrite, PCWrite, AdrSrc, ALUSrcB, MemWrite} !== 6'b110100) begin
            fails++; $display("FAIL mid_reset_fetch got %b exp 110100", {IRWrite, PCWrite, AdrSrc, ALUSrcB, MemWrite});
        end
        Op = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int b;
        logic [3:0] rd;
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 60; k++) begin
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            do_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                     rd, 4'($urandom_range(0, 15)), b);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            asserts++;
            if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL random cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_subs_beq();
        test_cond_fail();
        test_mem();
        test_orr_ands();
        test_pc_write();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
